pipelined_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder: the multi-bit, registered successor to the single-bit full adder.
- WIDTH-bit operands are split into SEG-bit slices. One slice is added per pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on both sides. Throughput is one operation per cycle; latency is WIDTH/SEG cycles.
- Sits in the CPU datapath as the ALU add path, and as a reusable adder for address/PC arithmetic.

---
 rtl/adder_pkg.sv | 14 +
 rtl/add_slice.sv | 25 ++
 rtl/pipelined_adder.sv | 109 ++++++++++
 tb/tb_pipelined_adder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared helpers for the pipelined ripple-carry adder
package adder_pkg;

    // Pipeline depth: one stage per SEG-bit slice of the operands.
    function automatic int calc_nstages(input int width, input int seg);
        return width / seg;
    endfunction

    // Two's-complement overflow from the sign bits of both addends and the result.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational SEG-bit ripple-carry adder slice
module add_slice #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic c;

    // Bit-serial ripple: each bit consumes the carry of the bit below it.
    always_comb begin
        s = '0;
        c = cin;
        for (int i = 0; i < SEG; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined ripple-carry adder, optional subtract via ADDER_ADDSUB_EN
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
`ifdef ADDER_ADDSUB_EN
    ,
    input  logic             sub
`endif
);

    localparam int NSTAGES = calc_nstages(WIDTH, SEG);

    if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of SEG");
    end

    // One pipeline record: b holds the effective (possibly inverted) operand,
    // sum holds the low slices completed so far.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
    } stage_t;

    stage_t st [NSTAGES];

    logic advance;
    logic sub_sel;

`ifdef ADDER_ADDSUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // The whole pipeline freezes only while a finished result is waiting on the consumer.
    assign advance  = !(st[NSTAGES-1].valid && !out_ready);
    assign in_ready = advance && !rst;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        stage_t         prev;
        logic [SEG-1:0] op_a;
        logic [SEG-1:0] op_b;
        logic [SEG-1:0] s;
        logic           cout;

        if (k == 0) begin : g_first
            // Stage 0 sees the raw beat; subtraction inverts b and the carry here once.
            always_comb begin
                prev       = '0;
                prev.valid = in_valid && in_ready;
                prev.carry = c_in ^ sub_sel;
                prev.a     = a;
                prev.b     = sub_sel ? ~b : b;
                prev.sub   = sub_sel;
            end
        end else begin : g_next
            assign prev = st[k-1];
        end

        assign op_a = prev.a[k*SEG +: SEG];
        assign op_b = prev.b[k*SEG +: SEG];

        add_slice #(.SEG(SEG)) u_slice (
            .a    (op_a),
            .b    (op_b),
            .cin  (prev.carry),
            .s    (s),
            .cout (cout)
        );

        // Capture the record from upstream with this stage's slice result merged in.
        always_ff @(posedge clk) begin
            if (rst) begin
                st[k] <= '0;
            end else if (advance) begin
                st[k]                    <= prev;
                st[k].sum[k*SEG +: SEG]  <= s;
                st[k].carry              <= cout;
            end
        end
    end

    assign out_valid = st[NSTAGES-1].valid;
    assign sum       = st[NSTAGES-1].sum;
    assign c_out     = st[NSTAGES-1].carry;
    assign ovf       = signed_ovf(st[NSTAGES-1].a[WIDTH-1],
                                  st[NSTAGES-1].b[WIDTH-1],
                                  st[NSTAGES-1].sum[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed self-checking bench for pipelined_adder
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf, sub;
    logic [31:0] a, b, sum;

    logic        in_valid1, in_ready1, c_in1, out_valid1, c_out1, ovf1;
    logic [0:0]  a1, b1, sum1;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .SEG(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
`ifdef ADDER_ADDSUB_EN
        ,
        .sub       (sub)
`endif
    );

    pipelined_adder #(.WIDTH(1), .SEG(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .c_in      (c_in1),
        .out_valid (out_valid1),
        .out_ready (1'b1),
        .sum       (sum1),
        .c_out     (c_out1),
        .ovf       (ovf1)
`ifdef ADDER_ADDSUB_EN
        ,
        .sub       (1'b0)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic cv, input logic [31:0] es, input logic ec, input logic eo);
        int n;
        a = av; b = bv; c_in = cv; in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_c_out"}, c_out, ec);
        chk({tag, "_ovf"}, ovf, eo);
        tick();
    endtask

    logic [1:0] fa_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic       mv [4];
    logic       stall, acc;
    int         sent, got, cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 0);
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_valid_w1", out_valid1, 0);
        rst = 1'b0;
        tick();

        run_one("wrap",   32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("posovf", 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        run_one("cin",    32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0);

        // Full-adder truth table on the single-stage instance, latency 1.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            a1 = v[2]; b1 = v[1]; c_in1 = v[0]; in_valid1 = 1'b1;
            tick();
            chk("w1_valid", out_valid1, 1);
            chk("w1_result", {c_out1, sum1}, fa_tab[i]);
        end
        in_valid1 = 1'b0;
        tick();
        chk("w1_bubble", out_valid1, 0);

        // Back-to-back stream with out_ready toggling every cycle.
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        sent = 0; got = 0; cyc = 0;
        while ((sent < 10 || got < 10) && cyc < 200) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (sent < 10);
            a = sent; b = 100 * sent; c_in = 1'b0;
            #1;
            stall = mv[3] && !out_ready;
            chk("stream_in_ready", in_ready, !stall);
            chk("stream_out_valid", out_valid, mv[3]);
            if (mv[3] && out_ready) begin
                chk("stream_sum", sum, 101 * got);
                got++;
            end
            acc = in_valid && !stall;
            if (acc) sent++;
            if (!stall) begin
                mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = mv[0]; mv[0] = acc;
            end
            tick();
            cyc++;
        end
        chk("stream_count", got, 10);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Reset with three beats in flight.
        for (int i = 1; i <= 3; i++) begin
            a = i; b = 32'h10; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_c_out", c_out, 0);
        chk("midrst_ovf", ovf, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_ghost", out_valid, 0);
        end
        run_one("after_rst", 32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0);

`ifdef ADDER_ADDSUB_EN
        sub = 1'b1;
        run_one("sub_neg", 32'h5,         32'h7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_pos", 32'h7,         32'h5, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
        run_one("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        sub = 1'b0;
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
